// File: rtl/registrador_paralelo_serial_if.sv
// Load handshake and serial output bundle of the parallel-to-serial transmitter.
// master drives the word and load_valid; slave is the shifter.
interface registrador_paralelo_serial_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, out, out_valid, busy, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/registrador_paralelo_serial.sv
// Parallel-in/serial-out shifter: bit i of a word loaded at edge k is on out after edge k+i.
// load_ready only when idle or on the last bit, so a held load_valid streams words gap-free.
module registrador_paralelo_serial #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clock,
    input  logic                         clear_n,
    registrador_paralelo_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [CW-1:0]    cnt;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             last_bit;

    // The vacated end is zero-filled so an idle register always reads 0 on out.
    assign sr_shift = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    assign bus.load_ready = (state == IDLE) || last_bit;
    assign bus.out        = LSB_FIRST ? sr[0] : sr[WIDTH-1];
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        sr          <= bus.data_in;
                        cnt         <= '0;
                        state       <= SHIFT;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sr  <= sr_shift;
                        cnt <= cnt + 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        cnt    <= '0;
                        if (bus.load_valid) begin
                            sr <= bus.data_in;
                        end else begin
                            sr          <= '0;
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_registrador_paralelo_serial.sv
// Bench for the parallel-to-serial transmitter: a 4-bit LSB-first instance with a looped
// 4-bit receiver and scoreboard, and an 8-bit MSB-first instance driven by hand.
module tb_registrador_paralelo_serial;
    logic clock   = 1'b0;
    logic clear_n = 1'b1;

    always #5 clock = ~clock;

    registrador_paralelo_serial_if #(.WIDTH(4)) if4 ();
    registrador_paralelo_serial_if #(.WIDTH(8)) if8 ();

    registrador_paralelo_serial #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (if4)
    );

    registrador_paralelo_serial #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (if8)
    );

    typedef struct {
        logic       b;
        bit         last;
        logic [3:0] word;
    } sb_t;

    typedef struct {
        logic [3:0] data;
        logic [0:3] seq;   // transmission order, leftmost bit first
        bit         hold;  // keep load_valid high into the next entry
    } vec_t;

    sb_t  sb[$];
    int   dtimes[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   vcount = 0;
    int   dones  = 0;
    bit   exp_done = 1'b0;
    logic [3:0] exp_word = '0;
    logic [3:0] rx = '0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Receiver: Q3 is the entry stage, Q0 holds the oldest bit.
    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) rx <= '0;
        else          rx <= {if4.out, rx[3:1]};
    end

    always @(negedge clock) begin
        sb_t e;
        cyc++;
        if (!clear_n) begin
            sb.delete();
            exp_done = 1'b0;
        end else begin
            chk("done", int'(if4.done), int'(exp_done));
            if (if4.done) begin
                dones++;
                dtimes.push_back(cyc);
            end
            if (exp_done) chk("rx_word", int'(rx), int'(exp_word));
            exp_done = 1'b0;
            chk("load_ready", int'(if4.load_ready), int'(sb.size() <= 1));
            chk("out_valid", int'(if4.out_valid), int'(sb.size() != 0));
            chk("busy", int'(if4.busy), int'(sb.size() != 0));
            if (if4.out_valid) vcount++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_bit", int'(if4.out), int'(e.b));
                if (e.last) begin
                    exp_done = 1'b1;
                    exp_word = e.word;
                end
            end else begin
                chk("idle_out", int'(if4.out), 0);
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [0:3] s, input bit hold);
        int n = 0;
        if4.data_in    = d;
        if4.load_valid = 1'b1;
        while (!if4.load_ready && n < 20) begin
            step();
            n++;
        end
        chk("load_accept", int'(if4.load_ready), 1);
        if (!if4.load_ready) begin
            if4.load_valid = 1'b0;
            return;
        end
        @(posedge clock);
        for (int i = 0; i < 4; i++) sb.push_back('{s[i], i == 3, d});
        #1;
        if (!hold) if4.load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || if4.busy) && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(n < 50), 1);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [0:7] seq8;
        int         v0;
        int         nw;
        int         d0;

        vecs[0] = '{4'b1011, 4'b1101, 1'b0};
        vecs[1] = '{4'hA,    4'b0101, 1'b1};
        vecs[2] = '{4'h5,    4'b1010, 1'b0};
        vecs[3] = '{4'h0,    4'b0000, 1'b0};
        vecs[4] = '{4'hF,    4'b1111, 1'b1};
        vecs[5] = '{4'h8,    4'b0001, 1'b1};
        vecs[6] = '{4'h6,    4'b0110, 1'b0};
        seq8    = 8'b11000011;

        if4.data_in = '0; if4.load_valid = 1'b0;
        if8.data_in = '0; if8.load_valid = 1'b0;

        // Reset state, checked before any clock edge.
        #1 clear_n = 1'b0;
        #1;
        chk("rst_out",        int'(if4.out), 0);
        chk("rst_out_valid",  int'(if4.out_valid), 0);
        chk("rst_busy",       int'(if4.busy), 0);
        chk("rst_done",       int'(if4.done), 0);
        chk("rst_load_ready", int'(if4.load_ready), 1);
        chk("rst_ready8",     int'(if8.load_ready), 1);
        step();
        step();
        clear_n = 1'b1;
        step();

        // Table: single words and back-to-back groups.
        v0 = vcount;
        nw = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) dtimes.delete();
            send(vecs[i].data, vecs[i].seq, vecs[i].hold);
            nw++;
            if (!vecs[i].hold) begin
                wait_idle();
                chk("valid_cycles", vcount - v0, 4 * nw);
                if (i == 2) begin
                    chk("b2b_done_count", dtimes.size(), 2);
                    if (dtimes.size() == 2) chk("b2b_done_gap", dtimes[1] - dtimes[0], 4);
                end
                v0 = vcount;
                nw = 0;
            end
        end

        // Load attempt while busy is refused and leaves the stream intact.
        send(4'h3, 4'b1100, 1'b0);
        step();
        if4.data_in    = 4'hF;
        if4.load_valid = 1'b1;
        chk("busy_ready_cnt1", int'(if4.load_ready), 0);
        step();
        chk("busy_ready_cnt2", int'(if4.load_ready), 0);
        if4.load_valid = 1'b0;
        wait_idle();
        chk("busy_then_idle", int'(if4.busy), 0);

        // 8-bit MSB-first word.
        if8.data_in    = 8'hC3;
        if8.load_valid = 1'b1;
        chk("w8_ready", int'(if8.load_ready), 1);
        step();
        if8.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("w8_bit", int'(if8.out), int'(seq8[i]));
            chk("w8_valid", int'(if8.out_valid), 1);
            chk("w8_done_early", int'(if8.done), 0);
            step();
        end
        chk("w8_done", int'(if8.done), 1);
        chk("w8_valid_off", int'(if8.out_valid), 0);
        step();
        chk("w8_done_pulse", int'(if8.done), 0);

        // Abort mid-word at cnt=2, then a clean frame.
        d0 = dones;
        send(4'h9, 4'b1001, 1'b0);
        step();
        step();
        clear_n = 1'b0;
        #1;
        chk("abort_out",        int'(if4.out), 0);
        chk("abort_out_valid",  int'(if4.out_valid), 0);
        chk("abort_busy",       int'(if4.busy), 0);
        chk("abort_done",       int'(if4.done), 0);
        chk("abort_load_ready", int'(if4.load_ready), 1);
        step();
        clear_n = 1'b1;
        step();
        chk("abort_no_done", dones - d0, 0);
        send(4'h6, 4'b0110, 1'b0);
        wait_idle();
        chk("abort_one_done", dones - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
